// File: rtl/poly_decompress_stream_pkg.sv
// Shared Kyber constants, compression-width encoding and FSM state encoding
// for the polynomial decompression stream.
package poly_decompress_stream_pkg;

  localparam int unsigned KYBER_N = 256;
  localparam int unsigned KYBER_Q = 3329;

  typedef enum logic [1:0] {
    DSel4  = 2'd0,
    DSel5  = 2'd1,
    DSel10 = 2'd2,
    DSel11 = 2'd3
  } d_sel_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Compression width in bits for a d_sel code.
  function automatic logic [3:0] d_width(logic [1:0] sel);
    logic [3:0] w;
    w = 4'd4;
    unique case (d_sel_e'(sel))
      DSel4:  w = 4'd4;
      DSel5:  w = 4'd5;
      DSel10: w = 4'd10;
      DSel11: w = 4'd11;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/poly_decompress_stream_if.sv
// Compressed-word input stream and decompressed-beat output stream of the
// polynomial decompressor; master is the environment, slave is the block.
interface poly_decompress_stream_if #(
  parameter int unsigned LANES = 4
);
  logic [63:0]         s_data;
  logic                s_valid;
  logic                s_ready;
  logic [12*LANES-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/poly_decompress_lane.sv
// One decompression lane: r = (c*Q + 2^(d-1)) >> d, with a 23-bit intermediate.
module poly_decompress_lane #(
  parameter int unsigned KYBER_Q = poly_decompress_stream_pkg::KYBER_Q
) (
  input  logic [10:0] c,
  input  logic [3:0]  d,
  output logic [11:0] r
);
  logic [22:0] sum;

  always_comb begin
    sum = 23'(c) * 23'(KYBER_Q) + (23'd1 << (d - 4'd1));
    r   = 12'(sum >> d);
  end
endmodule

// File: rtl/poly_decompress_stream.sv
// Streams 64-bit compressed words into a bit buffer and emits LANES
// decompressed 12-bit coefficients per beat through one output register.
module poly_decompress_stream #(
  parameter int unsigned KYBER_N = poly_decompress_stream_pkg::KYBER_N,
  parameter int unsigned KYBER_Q = poly_decompress_stream_pkg::KYBER_Q,
  parameter int unsigned LANES   = 4,
  parameter int unsigned BUF_W   = 128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] d_sel,
  output logic       busy,
  output logic       done,
  poly_decompress_stream_if.slave bus
);
  import poly_decompress_stream_pkg::*;

  localparam int unsigned Beats = KYBER_N / LANES;
  localparam int unsigned FillW = $clog2(BUF_W + 1);
  localparam int unsigned BeatW = $clog2(Beats + 1);

  state_e              state_q;
  logic [BUF_W-1:0]    bits_q, bits_d;
  logic [FillW-1:0]    fill_q, fill_d, base_fill, beat_bits;
  logic [5:0]          word_cnt_q, words_total;
  logic [BeatW-1:0]    beat_cnt_q;
  logic [3:0]          dw_q;
  logic [10:0]         d_mask;
  logic                accept, consume, out_hs;
  logic [10:0]         coef [LANES];
  logic [11:0]         lane_r [LANES];
  logic [12*LANES-1:0] beat_data;

  always_comb begin
    busy        = (state_q == StRun);
    words_total = {dw_q, 2'b00};
    beat_bits   = FillW'(LANES * 32'(dw_q));
    d_mask      = 11'((32'd1 << dw_q) - 32'd1);
    bus.s_ready = (state_q == StRun) && (word_cnt_q < words_total) &&
                  (32'(fill_q) <= BUF_W - 64);
    out_hs      = bus.m_valid && bus.m_ready;
    consume     = (state_q == StRun) && (fill_q >= beat_bits) && (32'(beat_cnt_q) < Beats) &&
                  (!bus.m_valid || bus.m_ready);
    accept      = bus.s_valid && bus.s_ready;
    // Consume first, then append the new word above what remains.
    bits_d      = consume ? (bits_q >> beat_bits) : bits_q;
    base_fill   = consume ? (fill_q - beat_bits) : fill_q;
    fill_d      = base_fill;
    if (accept) begin
      bits_d = bits_d | (BUF_W'(bus.s_data) << base_fill);
      fill_d = base_fill + FillW'(64);
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      coef[l] = 11'(bits_q >> (32'(l) * 32'(dw_q))) & d_mask;
      beat_data[12*l +: 12] = lane_r[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    poly_decompress_lane #(
      .KYBER_Q(KYBER_Q)
    ) u_lane (
      .c(coef[l]),
      .d(dw_q),
      .r(lane_r[l])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bits_q      <= '0;
      fill_q      <= '0;
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      dw_q        <= 4'd4;
      bus.m_data  <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            bits_q     <= '0;
            fill_q     <= '0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
            dw_q       <= d_width(d_sel);
          end
        end
        StRun: begin
          bits_q <= bits_d;
          fill_q <= fill_d;
          if (accept) word_cnt_q <= word_cnt_q + 6'd1;
          if (consume) begin
            bus.m_data  <= beat_data;
            bus.m_valid <= 1'b1;
            bus.m_last  <= (32'(beat_cnt_q) == Beats - 1);
            beat_cnt_q  <= beat_cnt_q + BeatW'(1);
          end else if (out_hs) begin
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
          end
          if (out_hs && bus.m_last) begin
            state_q <= StIdle;
            done    <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_poly_decompress_stream.sv
// Scoreboard bench: expected beats are computed from the fed words and
// compared against each output handshake.
module tb_poly_decompress_stream;
  localparam int unsigned LANES = 4;
  localparam int unsigned N     = 256;
  localparam int unsigned NB    = N / LANES;
  localparam int unsigned DW    = 12 * LANES;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] d_sel = 2'd0;
  logic       busy, done;

  poly_decompress_stream_if #(.LANES(LANES)) bus ();

  poly_decompress_stream #(
    .KYBER_N(N),
    .KYBER_Q(3329),
    .LANES(LANES),
    .BUF_W(128)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .d_sel(d_sel),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  logic [63:0]   words [44];
  logic [2815:0] stream;
  logic [DW:0]   exp_q [$];

  int         cfg_stall = 0;
  int         cfg_abort = -1;
  bit         cfg_poke = 0;
  bit         cfg_chain = 0;
  bit         cfg_pre = 0;
  logic [1:0] cfg_chain_dsel = 2'd0;

  int          r_words, r_beats;
  bit          r_late_ready, r_done_ok, r_timeout;
  logic [DW-1:0] r_first;

  function automatic int model(int c, int d);
    return (c * 3329 + (1 << (d - 1))) >> d;
  endfunction

  function automatic int dwidth(logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 5;
      2'd2:    return 10;
      default: return 11;
    endcase
  endfunction

  task automatic run_poly(input logic [1:0] dsel);
    int d, nw, idx, cyc, last_hs, k, c;
    logic [DW:0] e, got;
    logic [DW-1:0] prev_data;
    bit prev_stall, first;
    d  = dwidth(dsel);
    nw = 4 * d;
    stream = '0;
    for (int i = 0; i < nw; i++) stream[i*64 +: 64] = words[i];
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      e = '0;
      e[DW] = (b == NB - 1);
      for (int l = 0; l < LANES; l++) begin
        k = b * LANES + l;
        c = 0;
        for (int j = 0; j < d; j++) c |= int'(stream[k*d + j]) << j;
        e[12*l +: 12] = 12'(model(c, d));
      end
      exp_q.push_back(e);
    end

    if (!cfg_pre) begin
      @(posedge clk); #1;
      start = 1'b1;
      d_sel = dsel;
    end
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0; cyc = 0; last_hs = -10;
    r_words = 0; r_beats = 0; r_late_ready = 0; r_done_ok = 0; r_timeout = 0;
    prev_stall = 0; first = 1; prev_data = '0;
    bus.s_valid = (cfg_stall == 0) || ($urandom_range(0, 1) == 1);
    bus.s_data  = words[0];
    bus.m_ready = 1'b1;

    forever begin
      @(negedge clk);
      if (cyc == 0) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_in_run: busy=%b required 1", busy);
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (bus.m_data !== prev_data || bus.m_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: m_data=%h m_valid=%b required %h 1",
                   bus.m_data, bus.m_valid, prev_data);
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      if (idx == nw && bus.s_ready) r_late_ready = 1;
      if (bus.s_valid && bus.s_ready) begin
        idx++;
        r_words++;
      end
      if (bus.m_valid && bus.m_ready) begin
        got = {bus.m_last, bus.m_data};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_extra: got %h, required no beat", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL beat_%0d: got last=%b data=%h, required last=%b data=%h",
                     r_beats, got[DW], got[DW-1:0], e[DW], e[DW-1:0]);
          end
        end
        if (first) r_first = bus.m_data;
        first = 0;
        r_beats++;
        if (bus.m_last) last_hs = cyc;
      end
      if (done) begin
        r_done_ok = (last_hs == cyc - 1);
        break;
      end
      if (cfg_abort >= 0 && r_beats == cfg_abort) break;
      if (cyc > 4000) begin
        r_timeout = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cfg_poke && cyc == 30) begin
        start = 1'b1;
        d_sel = ~dsel;
      end else if (cfg_poke && cyc == 31) begin
        start = 1'b0;
      end
      if (cfg_chain && last_hs == cyc - 1) begin
        start = 1'b1;
        d_sel = cfg_chain_dsel;
      end
      bus.s_valid = (idx < nw) && ((cfg_stall == 0) || ($urandom_range(0, 1) == 1));
      bus.s_data  = (idx < nw) ? words[idx] : 64'd0;
      bus.m_ready = (cfg_stall == 0) || (cyc % 3 == 0);
    end

    if (cfg_abort < 0) begin
      n_vec++;
      if (r_timeout) begin
        n_fail++;
        $display("FAIL timeout: no done after %0d cycles, beats=%0d", cyc, r_beats);
      end
      n_vec++;
      if (r_beats != NB) begin
        n_fail++;
        $display("FAIL beat_count: got %0d required %0d", r_beats, NB);
      end
      n_vec++;
      if (r_words != nw) begin
        n_fail++;
        $display("FAIL word_count: got %0d required %0d", r_words, nw);
      end
      n_vec++;
      if (r_late_ready) begin
        n_fail++;
        $display("FAIL late_ready: s_ready=1 after last word, required 0");
      end
      n_vec++;
      if (!r_done_ok && !r_timeout) begin
        n_fail++;
        $display("FAIL done_timing: last handshake cycle %0d, done cycle %0d, required +1",
                 last_hs, cyc);
      end
    end
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    reset_n = 1'b0;
    #12;
    n_vec++;
    if ({bus.s_ready, bus.m_valid, bus.m_last, busy, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: s_ready/m_valid/m_last/busy/done=%b required 00000",
               {bus.s_ready, bus.m_valid, bus.m_last, busy, done});
    end
    n_vec++;
    if (bus.m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: m_data=%h required 0", bus.m_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.m_valid, bus.s_ready, busy} !== 3'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: m_valid/s_ready/busy=%b required 000",
                 {bus.m_valid, bus.s_ready, busy});
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_d4();
    for (int i = 0; i < 44; i++) words[i] = 64'h1111_1111_1111_1111;
    run_poly(2'd0);
    n_vec++;
    if (r_first !== {4{12'd208}}) begin
      n_fail++;
      $display("FAIL d4_value: got %h required %h", r_first, {4{12'd208}});
    end
    @(negedge clk);
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_pulse: done/busy=%b required 00", {done, busy});
    end
  endtask

  task automatic test_d11();
    for (int i = 0; i < 44; i++) words[i] = '1;
    run_poly(2'd3);
    n_vec++;
    if (r_first !== {4{12'd3327}}) begin
      n_fail++;
      $display("FAIL d11_value: got %h required %h", r_first, {4{12'd3327}});
    end
    n_vec++;
    if (r_words != 44) begin
      n_fail++;
      $display("FAIL d11_words: got %0d required 44", r_words);
    end
  endtask

  task automatic test_d10_pattern();
    logic [9:0] pat [4];
    pat = '{10'd0, 10'd1, 10'd512, 10'd1023};
    stream = '0;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 10; j++) stream[k*10 + j] = pat[k % 4][j];
    for (int i = 0; i < 40; i++) words[i] = stream[i*64 +: 64];
    run_poly(2'd2);
    n_vec++;
    if (r_first !== {12'd3326, 12'd1665, 12'd3, 12'd0}) begin
      n_fail++;
      $display("FAIL d10_pattern: got %h required %h", r_first,
               {12'd3326, 12'd1665, 12'd3, 12'd0});
    end
  endtask

  task automatic test_d5_stall();
    for (int i = 0; i < 44; i++) words[i] = {$urandom, $urandom};
    words[0][4:0] = 5'h1f;
    cfg_stall = 1;
    run_poly(2'd1);
    cfg_stall = 0;
    n_vec++;
    if (r_first[11:0] !== 12'd3225) begin
      n_fail++;
      $display("FAIL d5_max: got %0d required 3225", r_first[11:0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 44; i++) words[i] = {$urandom, $urandom};
    cfg_abort = 20;
    run_poly(2'd2);
    cfg_abort = -1;
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.s_ready, bus.m_valid, bus.m_last, busy, done} !== 5'b0 || bus.m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: ctrl=%b m_data=%h required 00000 0",
               {bus.s_ready, bus.m_valid, bus.m_last, busy, done}, bus.m_data);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.m_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_idle: m_valid/busy=%b required 00", {bus.m_valid, busy});
      end
    end
    for (int i = 0; i < 44; i++) words[i] = 64'h1111_1111_1111_1111;
    run_poly(2'd0);
    n_vec++;
    if (r_first !== {4{12'd208}}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %h required %h", r_first, {4{12'd208}});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 44; i++) words[i] = {$urandom, $urandom};
    cfg_poke = 1;
    cfg_chain = 1;
    cfg_chain_dsel = 2'd0;
    run_poly(2'd1);
    cfg_poke = 0;
    cfg_chain = 0;
    n_vec++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_gap: done/busy=%b required 10", {done, busy});
    end
    for (int i = 0; i < 44; i++) words[i] = {$urandom, $urandom};
    cfg_pre = 1;
    run_poly(2'd0);
    cfg_pre = 0;
  endtask

  initial begin
    test_reset();
    test_d4();
    test_d11();
    test_d10_pattern();
    test_d5_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
